// File: rtl/branch_predictor.sv
// branch_predictor
// ----------------
// Direct-mapped branch target buffer with a 2-bit saturating counter per
// entry. The IF stage gets a zero-latency taken/target prediction for the PC
// it is fetching. The EX stage trains the table when a branch or jump
// resolves, and gets back a mispredict flag plus the corrected next PC.
// Two free-running 32-bit counters track resolved branches and mispredicts.
//
// Ports
//   cpu_clk, cpu_rst    core clock, synchronous active-high reset
//   if_pc               PC being fetched
//   pred_hit            table entry valid and tag matches if_pc
//   pred_taken          predicted taken for if_pc
//   pred_target         predicted next PC (table target or if_pc+4)
//   ex_update           branch/jump resolving in EX this cycle (pre-gated)
//   ex_pc               PC of the resolving instruction
//   ex_is_jump          instruction is unconditional (jal/jalr)
//   ex_taken            actual outcome
//   ex_target           actual target when taken
//   ex_pred_taken       prediction that travelled with the instruction
//   ex_pred_target      predicted target that travelled with the instruction
//   mispredict          outcome differs from prediction, redirect + flush
//   redirect_pc         correct next PC
//   perf_branches       number of ex_update cycles (wrapping)
//   perf_mispredicts    number of mispredict cycles (wrapping)

module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              ex_update,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_is_jump,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       perf_branches,
    output logic [31:0]       perf_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [1:0]        cnt_q    [ENTRIES];
    logic              jmp_q    [ENTRIES];

    logic [31:0]       perf_branches_q;
    logic [31:0]       perf_mispredicts_q;

    logic [IDX_W-1:0]  if_idx;
    logic [TAG_W-1:0]  if_tag;
    logic [IDX_W-1:0]  ex_idx;
    logic [TAG_W-1:0]  ex_tag;
    logic              ex_hit;
    logic [ADDR_W-1:0] if_pc_plus4;
    logic [ADDR_W-1:0] ex_pc_plus4;

    // Byte offset bits are ignored; the word index selects the entry and the
    // remaining upper bits form the tag.
    assign if_idx      = if_pc[IDX_W+1:2];
    assign if_tag      = if_pc[ADDR_W-1:IDX_W+2];
    assign ex_idx      = ex_pc[IDX_W+1:2];
    assign ex_tag      = ex_pc[ADDR_W-1:IDX_W+2];
    assign if_pc_plus4 = if_pc + ADDR_W'(4);
    assign ex_pc_plus4 = ex_pc + ADDR_W'(4);
    assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Fetch-side lookup. It reads the registered table only, so an update to
    // the same entry in this cycle is not visible until the next cycle. Reset
    // masks the hit so that fetch sees fall-through while the table is being
    // cleared.
    always_comb begin
        pred_hit    = !cpu_rst && valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = pred_hit && (jmp_q[if_idx] || cnt_q[if_idx][1]);
        pred_target = pred_taken ? target_q[if_idx] : if_pc_plus4;
    end

    // Resolve-side check. A taken branch that was predicted taken can still
    // be wrong if the target changed (e.g. jalr to a different register).
    always_comb begin
        mispredict  = ex_update &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && (ex_target != ex_pred_target)));
        redirect_pc = ex_taken ? ex_target : ex_pc_plus4;
    end

    // Table training. Hits move the counter toward the outcome and refresh
    // the target only when taken, so a not-taken pass leaves the last known
    // target for later. Taken misses evict whatever occupies the slot and
    // start weakly taken; not-taken misses never allocate, keeping the table
    // for branches that actually redirect. Tag and target need no reset
    // because valid gates every use of them.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'd1;
                jmp_q[i]   <= 1'b0;
            end
        end else if (ex_update) begin
            if (ex_hit) begin
                if (ex_taken) begin
                    if (cnt_q[ex_idx] != 2'd3) begin
                        cnt_q[ex_idx] <= cnt_q[ex_idx] + 2'd1;
                    end
                    target_q[ex_idx] <= ex_target;
                end else if (cnt_q[ex_idx] != 2'd0) begin
                    cnt_q[ex_idx] <= cnt_q[ex_idx] - 2'd1;
                end
                jmp_q[ex_idx] <= ex_is_jump;
            end else if (ex_taken) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                cnt_q[ex_idx]    <= 2'd2;
                jmp_q[ex_idx]    <= ex_is_jump;
            end
        end
    end

    // Performance counters wrap freely; software is expected to take deltas.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            perf_branches_q    <= 32'd0;
            perf_mispredicts_q <= 32'd0;
        end else begin
            if (ex_update) begin
                perf_branches_q <= perf_branches_q + 32'd1;
            end
            if (mispredict) begin
                perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
            end
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;

endmodule
